// File: rtl/score_keeper.sv
// Score keeper: two-digit BCD score and high score, IDLE/PLAY/OVER game FSM,
// and registered seven-segment codes for the on-screen digit renderer.
module score_keeper #(
  parameter bit BLANK_TENS = 1'b1,
  parameter int SAT_SCORE  = 99
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_start,
  input  logic        point,
  input  logic        game_over,
  output logic [7:0]  score_bcd,
  output logic [7:0]  high_bcd,
  output logic [13:0] seg,
  output logic [13:0] seg_high,
  output logic        playing,
  output logic        new_high
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam logic [3:0]  SAT_TENS  = 4'(SAT_SCORE / 10);
  localparam logic [3:0]  SAT_UNITS = 4'(SAT_SCORE % 10);
  localparam logic [7:0]  SAT_BCD   = {SAT_TENS, SAT_UNITS};
  localparam logic [13:0] SEG_RESET = BLANK_TENS ? 14'h007E : 14'h3F7E;

  // Current FSM state; kept as a named register so checkers can bind to it.
  state_t state;
  state_t state_nx;

  logic [7:0] score_nx;
  logic [7:0] high_nx;
  logic [7:0] score_inc;
  logic       new_high_nx;

  function automatic logic [6:0] enc_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  function automatic logic [13:0] enc_pair(input logic [7:0] v);
    logic [6:0] tens;
    tens = enc_digit(v[7:4]);
    if (BLANK_TENS && (v[7:4] == 4'd0)) tens = 7'b0000000;
    return {tens, enc_digit(v[3:0])};
  endfunction

  // Saturating BCD increment: holds at SAT_BCD rather than wrapping.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == SAT_BCD)         r = v;
    else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
    else                      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic bcd_gt(input logic [7:0] a, input logic [7:0] b);
    return (a[7:4] > b[7:4]) || ((a[7:4] == b[7:4]) && (a[3:0] > b[3:0]));
  endfunction

  always_comb begin
    state_nx    = state;
    score_nx    = score_bcd;
    high_nx     = high_bcd;
    new_high_nx = new_high;
    score_inc   = point ? bcd_inc(score_bcd) : score_bcd;
    case (state)
      S_IDLE, S_OVER: begin
        if (game_start) begin
          state_nx    = S_PLAY;
          score_nx    = 8'h00;
          new_high_nx = 1'b0;
        end
      end
      S_PLAY: begin
        // game_start dominates point and game_over; otherwise the point is
        // counted before the high-score compare on the same edge.
        if (game_start) begin
          score_nx = 8'h00;
        end else begin
          score_nx = score_inc;
          if (game_over) begin
            state_nx = S_OVER;
            if (bcd_gt(score_inc, high_bcd)) begin
              high_nx     = score_inc;
              new_high_nx = 1'b1;
            end
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      score_bcd <= 8'h00;
      high_bcd  <= 8'h00;
      playing   <= 1'b0;
      new_high  <= 1'b0;
      seg       <= SEG_RESET;
      seg_high  <= SEG_RESET;
    end else begin
      state     <= state_nx;
      score_bcd <= score_nx;
      high_bcd  <= high_nx;
      playing   <= (state_nx == S_PLAY);
      new_high  <= new_high_nx;
      // Encoder stage runs one edge behind the BCD registers.
      seg       <= enc_pair(score_bcd);
      seg_high  <= enc_pair(high_bcd);
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: a decimal reference model pushes expected outputs
// per driven cycle into a queue, popped and compared after each clock edge.
module tb_score_keeper;

  localparam bit BLANK_TENS = 1'b1;
  localparam int SAT_SCORE  = 99;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        game_start = 1'b0;
  logic        point = 1'b0;
  logic        game_over = 1'b0;
  logic [7:0]  score_bcd;
  logic [7:0]  high_bcd;
  logic [13:0] seg;
  logic [13:0] seg_high;
  logic        playing;
  logic        new_high;

  score_keeper #(.BLANK_TENS(BLANK_TENS), .SAT_SCORE(SAT_SCORE)) dut (
    .clk        (clk),
    .reset      (reset),
    .game_start (game_start),
    .point      (point),
    .game_over  (game_over),
    .score_bcd  (score_bcd),
    .high_bcd   (high_bcd),
    .seg        (seg),
    .seg_high   (seg_high),
    .playing    (playing),
    .new_high   (new_high)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Entry layout: {seg[13:0], seg_high[13:0], score[7:0], high[7:0], playing, new_high}
  logic [45:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  int m_state = 0;   // 0 idle, 1 play, 2 over
  int m_score = 0;
  int m_high  = 0;
  bit m_nh    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  function automatic logic [13:0] enc2(input int v);
    logic [6:0] t;
    t = dig(v / 10);
    if (BLANK_TENS && (v / 10 == 0)) t = 7'b0;
    return {t, dig(v % 10)};
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_score = 0;
    m_high  = 0;
    m_nh    = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit gs, input bit pt, input bit go);
    logic [13:0] s_exp, sh_exp;
    logic [45:0] e;
    game_start = gs;
    point      = pt;
    game_over  = go;
    s_exp  = enc2(m_score);
    sh_exp = enc2(m_high);
    if (m_state == 1) begin
      if (gs) m_score = 0;
      else begin
        if (pt && m_score < SAT_SCORE) m_score++;
        if (go) begin
          m_state = 2;
          if (m_score > m_high) begin
            m_high = m_score;
            m_nh   = 1'b1;
          end
        end
      end
    end else if (gs) begin
      m_state = 1;
      m_score = 0;
      m_nh    = 1'b0;
    end
    exp_q.push_back({s_exp, sh_exp, to_bcd(m_score), to_bcd(m_high), (m_state == 1), m_nh});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("seg",       32'(seg),       32'(e[45:32]));
    check("seg_high",  32'(seg_high),  32'(e[31:18]));
    check("score_bcd", 32'(score_bcd), 32'(e[17:10]));
    check("high_bcd",  32'(high_bcd),  32'(e[9:2]));
    check("playing",   32'(playing),   32'(e[1]));
    check("new_high",  32'(new_high),  32'(e[0]));
    game_start = 1'b0;
    point      = 1'b0;
    game_over  = 1'b0;
  endtask

  task automatic points(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_score"},    32'(score_bcd), 32'h00);
    check({tag, "_high"},     32'(high_bcd),  32'h00);
    check({tag, "_seg"},      32'(seg),       32'h007E);
    check({tag, "_seg_high"}, 32'(seg_high),  32'h007E);
    check({tag, "_playing"},  32'(playing),   32'h0);
    check({tag, "_new_high"}, 32'(new_high),  32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    check_reset_values("reset");

    // 12 points, encoder lags one edge
    step(1, 0, 0);
    points(12);
    check("score12", 32'(score_bcd), 32'h12);
    step(0, 0, 0);
    check("seg12", 32'(seg), 32'h186D);

    // restart, 7-point game beats high of 00
    step(1, 0, 0);
    points(7);
    step(0, 0, 1);
    check("over7_high", 32'(high_bcd), 32'h07);
    check("over7_nh",   32'(new_high), 32'h1);
    check("over7_play", 32'(playing),  32'h0);
    points(3);  // ignored in OVER
    check("over_pts_ignored", 32'(score_bcd), 32'h07);

    // 5-point game does not beat 07
    step(1, 0, 0);
    points(5);
    step(0, 0, 1);
    check("over5_high", 32'(high_bcd), 32'h07);
    check("over5_nh",   32'(new_high), 32'h0);

    // tie at 07 does not set new_high
    step(1, 0, 0);
    points(7);
    step(0, 0, 1);
    check("tie_nh", 32'(new_high), 32'h0);

    // build high 09, then point+game_over at 09
    step(1, 0, 0);
    points(9);
    step(0, 0, 1);
    step(1, 0, 0);
    points(9);
    step(0, 1, 1);
    check("pt_go_score", 32'(score_bcd), 32'h10);
    check("pt_go_high",  32'(high_bcd),  32'h10);
    check("pt_go_nh",    32'(new_high),  32'h1);
    check("pt_go_over",  32'(dut.state), 32'd2);

    // simultaneous start+over and start+point in PLAY
    step(1, 0, 0);
    points(4);
    step(1, 0, 1);
    check("gs_go_play",  32'(playing),   32'h1);
    check("gs_go_high",  32'(high_bcd),  32'h10);
    points(2);
    step(1, 1, 0);
    check("gs_pt_score", 32'(score_bcd), 32'h00);

    // saturation at 99
    points(105);
    check("sat_score", 32'(score_bcd), 32'h99);
    step(0, 0, 0);
    check("sat_seg", 32'(seg), 32'h3DFB);

    // async reset mid-PLAY at score 34
    step(1, 0, 0);
    points(34);
    check("pre_rst_score", 32'(score_bcd), 32'h34);
    #2 reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    points(4);
    check("idle_pts_score", 32'(score_bcd), 32'h00);

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
